// File: rtl/spi_slave_frame_ctrl.sv
// SPI slave front end: frames MOSI commands {cmd, payload} for the RAM and shifts read data
// out on MISO. Define SPI_SLAVE_PARITY_EN to append one even-parity bit to every frame.
module spi_slave_frame_ctrl #(
  parameter int ADDR_SIZE  = 8,
  parameter int TX_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SS_n,
  input  logic                 MOSI,
  input  logic                 tx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  output logic                 MISO,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic [2:0]           state_dbg
);

  localparam int FW = ADDR_SIZE + 2;
`ifdef SPI_SLAVE_PARITY_EN
  localparam int NSHIFT = FW;
`else
  localparam int NSHIFT = FW - 1;
`endif
  localparam int BCW = $clog2(NSHIFT + 1);
  localparam int TCW = $clog2(TX_TIMEOUT + 1);
  localparam int SCW = $clog2(ADDR_SIZE + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4,
    WAIT_TX   = 3'd5,
    SEND      = 3'd6
  } state_t;

  state_t                state;
  logic [FW-1:0]         shreg;
  logic [BCW-1:0]        bit_cnt;
  logic                  bits_full;
  logic                  frame_done;
  logic                  rd_addr_pending;
  logic [TCW-1:0]        wait_cnt;
  logic [SCW-1:0]        send_cnt;
  logic [ADDR_SIZE-1:0]  tx_shreg;
  logic                  bit_last;
  logic                  frame_ok;

  // Handshakes: rx_valid is a one-cycle strobe with no back-pressure (rx_data is stable
  // from that strobe until the next one); tx_valid is a one-cycle strobe that is only
  // honoured in WAIT_TX and ignored in every other state.

  assign bit_last  = (bit_cnt == BCW'(NSHIFT - 1));
  assign busy      = (state != IDLE);
  assign state_dbg = state;

`ifdef SPI_SLAVE_PARITY_EN
  logic par_bit;
  logic par_err_q;
  assign frame_ok   = ((^shreg) == par_bit);
  assign parity_err = par_err_q;
`else
  assign frame_ok   = 1'b1;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      shreg           <= '0;
      bit_cnt         <= '0;
      bits_full       <= 1'b0;
      frame_done      <= 1'b0;
      rd_addr_pending <= 1'b0;
      wait_cnt        <= '0;
      send_cnt        <= '0;
      tx_shreg        <= '0;
      rx_data         <= '0;
      rx_valid        <= 1'b0;
      MISO            <= 1'b0;
      frame_err       <= 1'b0;
`ifdef SPI_SLAVE_PARITY_EN
      par_bit         <= 1'b0;
      par_err_q       <= 1'b0;
`endif
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      MISO      <= 1'b0;
`ifdef SPI_SLAVE_PARITY_EN
      par_err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          bit_cnt    <= '0;
          bits_full  <= 1'b0;
          frame_done <= 1'b0;
          if (!SS_n) state <= CHK_CMD;
        end

        CHK_CMD: begin
          if (SS_n) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else begin
            shreg <= {{(FW-1){1'b0}}, MOSI};
            if (!MOSI)                state <= WRITE;
            else if (rd_addr_pending) state <= READ_DATA;
            else                      state <= READ_ADD;
          end
        end

        WRITE, READ_ADD, READ_DATA: begin
          if (!bits_full) begin
            // The last bit wins over a simultaneous SS_n rise: the frame is complete.
            if (bit_last || !SS_n) begin
`ifdef SPI_SLAVE_PARITY_EN
              if (bit_last) par_bit <= MOSI;
              else          shreg   <= {shreg[FW-2:0], MOSI};
`else
              shreg <= {shreg[FW-2:0], MOSI};
`endif
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_last) bits_full <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end
          end else if (!frame_done) begin
            frame_done <= 1'b1;
            if (frame_ok) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              if (state == READ_ADD)       rd_addr_pending <= 1'b1;
              else if (state == READ_DATA) rd_addr_pending <= 1'b0;
            end
`ifdef SPI_SLAVE_PARITY_EN
            else par_err_q <= 1'b1;
`endif
          end else if (state == READ_DATA && frame_ok) begin
            wait_cnt <= '0;
            state    <= WAIT_TX;
          end else if (SS_n) begin
            state <= IDLE;
          end
        end

        WAIT_TX: begin
          if (SS_n) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else if (tx_valid) begin
            tx_shreg <= tx_data;
            send_cnt <= '0;
            state    <= SEND;
          end else if (wait_cnt == TCW'(TX_TIMEOUT - 1)) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        SEND: begin
          if (SS_n) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else if (send_cnt == SCW'(ADDR_SIZE)) begin
            state <= IDLE;
          end else begin
            MISO     <= tx_shreg[ADDR_SIZE-1];
            tx_shreg <= tx_shreg << 1;
            send_cnt <= send_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
